// File: rtl/dac_sample_pacer.sv
// Paced sample FIFO feeding a DAC: primes to PRIME_LVL, then releases one code per rate_div+1 cycles.
// Optional build macro DAC_MIDSCALE_ON_UNDERFLOW_EN parks the DAC at midscale on an empty tick.
module dac_sample_pacer #(
    parameter int DATA_W    = 10,
    parameter int DEPTH     = 8,
    parameter int PRIME_LVL = 4,
    parameter int DIV_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [DIV_W-1:0]         rate_div,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_W-1:0]        s_data,
    input  logic                     underflow_clr,
    output logic [DATA_W-1:0]        dac_data,
    output logic                     dac_strobe,
    output logic                     underflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [AW-1:0]     PTR_ONE   = AW'(1'b1);
    localparam logic [LW-1:0]     LVL_ONE   = LW'(1'b1);
    localparam logic [LW-1:0]     LVL_FULL  = LW'(DEPTH);
    localparam logic [LW-1:0]     LVL_PRIME = LW'(PRIME_LVL);
    localparam logic [DIV_W-1:0]  CNT_ONE   = DIV_W'(1'b1);
    localparam logic [DATA_W-1:0] MIDSCALE  = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic [DATA_W-1:0]   dac_data_q, dac_data_d;
    logic                dac_strobe_q, dac_strobe_d;
    logic                underflow_q, underflow_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                tick_s;
    logic                push_s;
    logic                pop_s;
    logic                empty_tick_s;

    assign s_ready    = (level_q != LVL_FULL);
    assign dac_data   = dac_data_q;
    assign dac_strobe = dac_strobe_q;
    assign underflow  = underflow_q;
    assign level      = level_q;

    // Playback state machine and sample-period counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_s  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = PRIME;
                end else begin
                    state_d = IDLE;
                end
            end
            PRIME: begin
                cnt_d = '0;
                if (!enable) begin
                    state_d = IDLE;
                end else if (level_q >= LVL_PRIME) begin
                    state_d = RUN;
                end else begin
                    state_d = PRIME;
                end
            end
            RUN: begin
                // >= so that lowering rate_div mid-period ticks right away
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= rate_div) begin
                    tick_s  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FIFO bookkeeping and DAC output next-state.
    always_comb begin
        push_s       = s_valid && s_ready;
        pop_s        = tick_s && (level_q != '0);
        empty_tick_s = tick_s && (level_q == '0);

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        if (pop_s) begin
            dac_data_d   = mem_q[rd_ptr_q];
            dac_strobe_d = 1'b1;
        end else if (empty_tick_s) begin
`ifdef DAC_MIDSCALE_ON_UNDERFLOW_EN
            dac_data_d   = MIDSCALE;
            dac_strobe_d = 1'b1;
`else
            dac_data_d   = dac_data_q;
            dac_strobe_d = 1'b0;
`endif
        end else begin
            dac_data_d   = dac_data_q;
            dac_strobe_d = 1'b0;
        end

        // An empty tick outranks a same-cycle clear
        if (empty_tick_s) begin
            underflow_d = 1'b1;
        end else if (underflow_clr) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            dac_data_q   <= '0;
            dac_strobe_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            dac_data_q   <= dac_data_d;
            dac_strobe_q <= dac_strobe_d;
            underflow_q  <= underflow_d;
        end
    end

    // Sample storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

endmodule

// File: tb/tb_dac_sample_pacer.sv
// Scoreboard bench for dac_sample_pacer: queue-based reference model, directed scenarios, random traffic.
module tb_dac_sample_pacer;

    localparam int DEPTH     = 8;
    localparam int PRIME_LVL = 4;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] rate_div;
    logic        s_valid;
    logic        s_ready;
    logic [9:0]  s_data;
    logic        underflow_clr;
    logic [9:0]  dac_data;
    logic        dac_strobe;
    logic        underflow;
    logic [3:0]  level;

    int checks   = 0;
    int failures = 0;
    int strobe_cnt = 0;

    // reference model state
    int mq[$];
    int exq[$];
    int mst   = 0;
    int cnt   = 0;
    int m_dac = 0;
    bit m_unf = 1'b0;
    bit m_strb = 1'b0;

    dac_sample_pacer dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .rate_div      (rate_div),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .underflow_clr (underflow_clr),
        .dac_data      (dac_data),
        .dac_strobe    (dac_strobe),
        .underflow     (underflow),
        .level         (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the reference model; decisions use pre-edge occupancy.
    task automatic model_step(input bit en, input int rd, input bit v, input int d, input bit clr);
        int  lvl;
        bit  tick;
        lvl    = mq.size();
        tick   = (mst == 2) && en && (cnt >= rd);
        m_strb = 1'b0;
        if (tick && lvl > 0) begin
            m_dac  = mq.pop_front();
            exq.push_back(m_dac);
            m_strb = 1'b1;
        end
`ifdef DAC_MIDSCALE_ON_UNDERFLOW_EN
        if (tick && lvl == 0) begin
            m_dac  = 512;
            exq.push_back(512);
            m_strb = 1'b1;
        end
`endif
        if (tick && lvl == 0) m_unf = 1'b1;
        else if (clr) m_unf = 1'b0;
        if (v && lvl != DEPTH) mq.push_back(d);
        if (mst == 2 && en) cnt = tick ? 0 : cnt + 1;
        else cnt = 0;
        if (mst == 0) begin
            if (en) mst = 1;
        end else if (mst == 1) begin
            if (!en) mst = 0;
            else if (lvl >= PRIME_LVL) mst = 2;
        end else begin
            if (!en) mst = 0;
        end
    endtask

    // Drive one cycle at a falling edge, step the model, then check at the next falling edge.
    task automatic cyc(input bit en, input int rd, input bit v, input int d, input bit clr);
        enable        = en;
        rate_div      = rd[15:0];
        s_valid       = v;
        s_data        = d[9:0];
        underflow_clr = clr;
        model_step(en, rd, v, d, clr);
        @(negedge clk);
        chk("level",      int'(level),      mq.size());
        chk("s_ready",    int'(s_ready),    (mq.size() != DEPTH) ? 1 : 0);
        chk("underflow",  int'(underflow),  int'(m_unf));
        chk("dac_data",   int'(dac_data),   m_dac);
        chk("dac_strobe", int'(dac_strobe), int'(m_strb));
    endtask

    task automatic do_reset();
        enable = 1'b0; s_valid = 1'b0; underflow_clr = 1'b0; rate_div = 16'd0; s_data = 10'd0;
        rst = 1'b0;
        #1;
        chk("rst_level",     int'(level),      0);
        chk("rst_dac_data",  int'(dac_data),   0);
        chk("rst_strobe",    int'(dac_strobe), 0);
        chk("rst_underflow", int'(underflow),  0);
        chk("rst_s_ready",   int'(s_ready),    1);
        mq.delete(); exq.delete();
        mst = 0; cnt = 0; m_dac = 0; m_unf = 1'b0; m_strb = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected code.
    initial begin
        int e;
        forever begin
            @(posedge clk);
            #1;
            if (rst === 1'b1 && dac_strobe === 1'b1) begin
                strobe_cnt++;
                checks++;
                if (exq.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_strobe: got code %0d expected no strobe", dac_data);
                end else begin
                    e = exq.pop_front();
                    if (int'(dac_data) != e) begin
                        failures++;
                        $display("FAIL sb_code: got %0d expected %0d", dac_data, e);
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b0; enable = 1'b0; rate_div = 16'd0; s_valid = 1'b0; s_data = 10'd0; underflow_clr = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        // Pacing at rate_div=3 with codes 1..6
        for (int i = 1; i <= 6; i++) cyc(1'b0, 3, 1'b1, i, 1'b0);
        strobe_cnt = 0;
        for (int i = 0; i < 30; i++) cyc(1'b1, 3, 1'b0, 0, 1'b0);
        chk("pacing_strobes", strobe_cnt, 6);
        do_reset();

        // Full FIFO: 9 offered with playback stopped, 9th held off
        for (int i = 0; i < 9; i++) cyc(1'b0, 0, 1'b1, 256 + i, 1'b0);
        chk("full_level", int'(level), 8);
        chk("full_ready", int'(s_ready), 0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 0, 1'b1, 264, 1'b0);
        for (int i = 0; i < 12; i++) cyc(1'b1, 0, 1'b0, 0, 1'b0);
        do_reset();

        // Underflow at rate_div=0, then clear arbitration
        cyc(1'b0, 0, 1'b1, 17, 1'b0);
        cyc(1'b0, 0, 1'b1, 34, 1'b0);
        cyc(1'b0, 0, 1'b1, 51, 1'b0);
        cyc(1'b0, 0, 1'b1, 68, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 0, 1'b0, 0, 1'b0);
        chk("unf_set", int'(underflow), 1);
`ifdef DAC_MIDSCALE_ON_UNDERFLOW_EN
        chk("unf_dac_midscale", int'(dac_data), 512);
`else
        chk("unf_dac_hold", int'(dac_data), 68);
`endif
        cyc(1'b1, 0, 1'b0, 0, 1'b1);
        chk("unf_clr_loses", int'(underflow), 1);
        cyc(1'b0, 0, 1'b0, 0, 1'b1);
        chk("unf_clr_wins", int'(underflow), 0);
        do_reset();

        // rate_div drop 100->2 with the counter at 50
        for (int i = 0; i < 8; i++) cyc(1'b0, 100, 1'b1, 600 + i, 1'b0);
        cyc(1'b1, 100, 1'b0, 0, 1'b0);
        cyc(1'b1, 100, 1'b0, 0, 1'b0);
        for (int i = 0; i < 50; i++) cyc(1'b1, 100, 1'b0, 0, 1'b0);
        chk("drop_no_early_strobe", strobe_cnt - strobe_cnt, 0);
        cyc(1'b1, 2, 1'b0, 0, 1'b0);
        chk("drop_immediate_tick", int'(dac_strobe), 1);
        for (int i = 0; i < 12; i++) cyc(1'b1, 2, 1'b0, 0, 1'b0);
        cyc(1'b0, 2, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 2, 1'b1, 700 + i, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 2, 1'b0, 0, 1'b0);

        // Reset mid-run with five samples queued
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b0, 1, 1'b1, 800 + i, 1'b0);
        guard = 0;
        while (mq.size() != 5 && guard < 40) begin
            cyc(1'b1, 1, 1'b0, 0, 1'b0);
            guard++;
        end
        chk("midrun_level5", int'(level), 5);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 9) != 0), int'($urandom_range(0, 4)),
                $urandom_range(0, 1) == 1, int'($urandom_range(0, 1023)),
                ($urandom_range(0, 19) == 0));
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b0, 0, 1'b0);
        chk("sb_drained", exq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
